// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, parity modes
// and the parity helper used by both directions of the link.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Widest data word any UART in the codebase supports.
    localparam int DATA_MAX = 16;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START_BIT  = 3'd1,
        DATA_BITS  = 3'd2,
        PARITY_BIT = 3'd3,
        STOP_BIT   = 3'd4
    } uart_state_t;

    // Parity bit a transmitter sends for this word; zero-padding is harmless to the XOR.
    function automatic logic parity_calc(input logic [DATA_MAX-1:0] data, input int ptype);
        logic p;
        p = 1'b0;
        if (ptype == PARITY_ODD)
            p = ~^data;
        else if (ptype == PARITY_EVEN)
            p = ^data;
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous input bit.
// RESET_VAL lets idle-high lines come out of reset in their idle state.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of start/data/parity/stop, one-entry output
// register with valid/ready handshake, overrun pulse when the word cannot land.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 50_000_000 / 115_200,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = PARITY_NONE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_in,
    output logic [BITS_N-1:0] data_rx,
    output logic              valid,
    input  logic              ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(BITS_N) + 1;
    localparam int HALF  = CLKS_PER_BIT / 2;

    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS_N - 1);

    logic              line_sync;
    logic              line_d;
    logic [2:0]        prime;
    logic              fall;

    uart_state_t       state;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_n;
    logic [BITS_N-1:0] shreg;
    logic [BITS_N:0]   shreg_in;
    logic              par_bit;

    logic              done;
    logic [BITS_N-1:0] pend_data;
    logic              pend_perr;
    logic              pend_ferr;

    sync_2ff #(.RESET_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_in),
        .q   (line_sync)
    );

    // The synchroniser drains its reset ones for a few cycles; a line held low
    // from reset must not look like a start edge, so edges are ignored until primed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_d <= 1'b1;
            prime  <= '0;
        end else begin
            line_d <= line_sync;
            prime  <= {prime[1:0], 1'b1};
        end
    end

    assign fall     = prime[2] && line_d && !line_sync;
    assign shreg_in = {line_sync, shreg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_n     <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            done      <= 1'b0;
            pend_data <= '0;
            pend_perr <= 1'b0;
            pend_ferr <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state <= START_BIT;
                        cnt   <= '0;
                    end
                end
                START_BIT: begin
                    if (cnt == CNT_MID) begin
                        cnt   <= '0;
                        bit_n <= '0;
                        state <= line_sync ? IDLE : DATA_BITS;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA_BITS: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        shreg <= shreg_in[BITS_N:1];
                        if (bit_n == BIT_LAST)
                            state <= (PARITY_TYPE == PARITY_NONE) ? STOP_BIT : PARITY_BIT;
                        else
                            bit_n <= bit_n + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY_BIT: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        par_bit <= line_sync;
                        state   <= STOP_BIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP_BIT: begin
                    // Back to IDLE at mid stop bit so a start edge right after it is not missed.
                    if (cnt == CNT_FULL) begin
                        cnt       <= '0;
                        state     <= IDLE;
                        done      <= 1'b1;
                        pend_data <= shreg;
                        pend_ferr <= !line_sync;
                        pend_perr <= (PARITY_TYPE != PARITY_NONE) &&
                                     (par_bit != parity_calc(DATA_MAX'(shreg), PARITY_TYPE));
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                // NOTE: a default arm keeps the case full, so no latch and no stuck unused encoding.
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_rx    <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!valid || ready) begin
                    data_rx    <= pend_data;
                    parity_err <= pend_perr;
                    frame_err  <= pend_ferr;
                    valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: three instances (no/odd/even parity) share reset;
// frames are queued with expected word, flags and arrival cycle, a monitor pops them.
module tb_uart_rx;

    localparam int C  = 16;
    localparam int N  = 8;
    localparam int NI = 3;

    typedef struct {
        int         inst;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         cyc;
    } exp_t;

    typedef struct {
        int inst;
        int cyc;
    } ovr_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NI-1:0]        line = '1;
    logic [NI-1:0]        ready = '1;
    logic [NI-1:0][7:0]   data_rx;
    logic [NI-1:0]        valid;
    logic [NI-1:0]        parity_err;
    logic [NI-1:0]        frame_err;
    logic [NI-1:0]        overrun;

    exp_t exp_q[$];
    ovr_t ovr_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    uart_rx #(.CLKS_PER_BIT(C), .BITS_N(N), .PARITY_TYPE(0)) u_rx0 (
        .clk(clk), .rst(rst), .uart_in(line[0]), .data_rx(data_rx[0]), .valid(valid[0]),
        .ready(ready[0]), .parity_err(parity_err[0]), .frame_err(frame_err[0]), .overrun(overrun[0]));
    uart_rx #(.CLKS_PER_BIT(C), .BITS_N(N), .PARITY_TYPE(1)) u_rx1 (
        .clk(clk), .rst(rst), .uart_in(line[1]), .data_rx(data_rx[1]), .valid(valid[1]),
        .ready(ready[1]), .parity_err(parity_err[1]), .frame_err(frame_err[1]), .overrun(overrun[1]));
    uart_rx #(.CLKS_PER_BIT(C), .BITS_N(N), .PARITY_TYPE(2)) u_rx2 (
        .clk(clk), .rst(rst), .uart_in(line[2]), .data_rx(data_rx[2]), .valid(valid[2]),
        .ready(ready[2]), .parity_err(parity_err[2]), .frame_err(frame_err[2]), .overrun(overrun[2]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (rx%0d): got 0x%0h, expected 0x%0h at cycle %0d", name, inst, act, exp, cyc);
        end
    endtask

    // Instance i is built with parity mode i: 0 none, 1 odd, 2 even.
    function automatic logic model_perr(input int i, input logic [7:0] d, input logic pbit);
        int ones;
        ones = $countones(d) + int'(pbit);
        if (i == 1) return (ones % 2) == 0;
        if (i == 2) return (ones % 2) == 1;
        return 1'b0;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int i, input logic b);
        line[i] = b;
        tick(C);
    endtask

    // Sends one frame and records what the receiver must do with it: deliver the
    // word (keep=1) or drop it with an overrun pulse (keep=0).
    task automatic send_frame(input int i, input logic [7:0] d, input logic pbit,
                              input logic stop, input bit keep, input int gap);
        exp_t e;
        ovr_t o;
        int   p;
        p      = (i != 0) ? 1 : 0;
        e.inst = i;
        e.data = d;
        e.perr = model_perr(i, d, pbit);
        e.ferr = !stop;
        e.cyc  = cyc + 3 + C / 2 + (N + p + 1) * C + 1;
        if (keep) begin
            exp_q.push_back(e);
        end else begin
            o.inst = i;
            o.cyc  = e.cyc;
            ovr_q.push_back(o);
        end
        drive_bit(i, 1'b0);
        for (int b = 0; b < N; b++) drive_bit(i, d[b]);
        if (p != 0) drive_bit(i, pbit);
        drive_bit(i, stop);
        line[i] = 1'b1;
        tick(gap);
    endtask

    logic [NI-1:0] prev_valid = '0;
    logic [NI-1:0] prev_hs    = '0;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = '0;
            prev_hs    = '0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (valid[i] && (!prev_valid[i] || prev_hs[i])) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", i, {24'd0, data_rx[i]}, 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check("word_instance", i, i, e.inst);
                        check("data_rx", i, {24'd0, data_rx[i]}, {24'd0, e.data});
                        check("parity_err", i, parity_err[i], e.perr);
                        check("frame_err", i, frame_err[i], e.ferr);
                        check("latency", i, cyc, e.cyc);
                    end
                end
                if (overrun[i]) begin
                    if (ovr_q.size() == 0) begin
                        check("unexpected_overrun", i, 1, 0);
                    end else begin
                        ovr_t o;
                        o = ovr_q.pop_front();
                        check("overrun_instance", i, i, o.inst);
                        check("overrun_cycle", i, cyc, o.cyc);
                    end
                end
                prev_valid[i] = valid[i];
                prev_hs[i]    = valid[i] && ready[i];
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        line[2] = 1'b0;
        tick(3);
        #2;
        for (int i = 0; i < NI; i++) begin
            check("reset_data_rx", i, {24'd0, data_rx[i]}, 0);
            check("reset_valid", i, valid[i], 0);
            check("reset_flags", i, {parity_err[i], frame_err[i], overrun[i]}, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(40);
        line[2] = 1'b1;
        tick(20);

        send_frame(0, 8'hA5, 1'b0, 1'b1, 1, C);

        line[0] = 1'b0;
        tick(5);
        line[0] = 1'b1;
        tick(2 * C);
        send_frame(0, 8'h3C, 1'b0, 1'b1, 1, C);

        send_frame(0, 8'h3C, 1'b0, 1'b0, 1, C);
        send_frame(0, 8'h81, 1'b0, 1'b1, 1, C);

        send_frame(2, 8'h07, 1'b0, 1'b1, 1, C);
        send_frame(2, 8'h07, 1'b1, 1'b1, 1, C);
        send_frame(1, 8'h07, 1'b0, 1'b1, 1, C);

        ready[0] = 1'b0;
        send_frame(0, 8'h11, 1'b0, 1'b1, 1, 0);
        send_frame(0, 8'h22, 1'b0, 1'b1, 0, 20);
        check("held_data_rx", 0, {24'd0, data_rx[0]}, 32'h11);
        check("held_valid", 0, valid[0], 1);
        ready[0] = 1'b1;
        tick(1);
        ready[0] = 1'b0;
        check("valid_after_accept", 0, valid[0], 0);
        send_frame(0, 8'h33, 1'b0, 1'b1, 1, C);
        check("unconsumed_valid", 0, valid[0], 1);

        d = 8'h5A;
        drive_bit(0, 1'b0);
        for (int b = 0; b < 3; b++) drive_bit(0, d[b]);
        line[0] = d[3];
        tick(C / 2);
        rst     = 1'b1;
        line[0] = 1'b1;
        #2;
        check("async_rst_data_rx", 0, {24'd0, data_rx[0]}, 0);
        check("async_rst_valid", 0, valid[0], 0);
        check("async_rst_data_rx", 2, {24'd0, data_rx[2]}, 0);
        @(posedge clk);
        #1;
        tick(3);
        rst      = 1'b0;
        ready[0] = 1'b1;
        tick(2 * C);
        send_frame(0, 8'h5A, 1'b0, 1'b1, 1, C);

        for (int k = 0; k < 36; k++) begin
            int         i;
            logic [7:0] rd;
            logic       pb;
            logic       sb;
            i  = $urandom_range(0, NI - 1);
            rd = 8'($urandom);
            pb = 1'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            send_frame(i, rd, pb, sb, 1, $urandom_range(2, 20));
        end

        for (int t = 0; t < 1000 && (exp_q.size() != 0 || ovr_q.size() != 0); t++) tick(1);
        check("words_outstanding", 0, exp_q.size(), 0);
        check("overruns_outstanding", 0, ovr_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the companion to the team's uart_tx. It recovers 8N1-style frames (parameterisable data width and parity) from an asynchronous serial line using mid-bit sampling. It presents each received word on a one-entry output register with a valid/ready handshake. It sits between the board RX pin and the downstream command/packet parser.

Parameters:
CLKS_PER_BIT, 50_000_000/115_200, clock cycles per bit period; must be >= 4.
BITS_N, 8, data bits per frame; 1..16.
PARITY_TYPE, 0, 0 = none, 1 = odd, 2 = even.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset; asynchronous, active-high.
uart_in  input  1  serial line, idle high, asynchronous to clk.
data_rx  output  BITS_N  received word, LSB received first.
valid  output  1  data_rx, parity_err and frame_err hold a word not yet consumed.
ready  input  1  downstream accepts the word this cycle when valid && ready.
parity_err  output  1  the held word failed its parity check; always 0 when PARITY_TYPE = 0.
frame_err  output  1  the held word's stop bit sampled 0.
overrun  output  1  one-cycle pulse: a frame completed while valid && !ready; the new word is dropped.

Behaviour:
- Reset values: data_rx = 0, valid = 0, parity_err = 0, frame_err = 0, overrun = 0.
- Reset internals: state = IDLE, counters = 0, synchroniser flops = 1.
- Reset mid-frame: the partial frame is discarded and nothing is emitted.
- Input path: 2-FF synchroniser, then one more register for edge detection.
- Start detection: falling edge of the synchronised line (previous sample 1, current sample 0).
  - A line held low from reset never triggers a frame; it must be seen high first.
- States: IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT. PARITY_BIT is skipped when PARITY_TYPE = 0.
- IDLE -> START_BIT on a falling edge; cycle counter cleared.
- START_BIT: count to CLKS_PER_BIT/2 - 1 (the mid-bit point), then sample the line.
  - Sample 0 -> DATA_BITS, counter cleared.
  - Sample 1 -> IDLE (glitch rejection).
- DATA_BITS: sample at every CLKS_PER_BIT - 1 count; shift the sample into bit index bit_n, LSB first.
  - After bit BITS_N-1 -> PARITY_BIT, or STOP_BIT when PARITY_TYPE = 0.
- PARITY_BIT: sample once at CLKS_PER_BIT - 1.
  - Error when the XOR of the data bits and the parity bit is 0 for odd parity, or 1 for even parity.
- STOP_BIT: sample at CLKS_PER_BIT - 1 (mid stop bit).
  - frame_err_next = !sample.
  - Return to IDLE in the same cycle, so the next start edge is caught without losing half a bit.
- Output register update, in the cycle after the stop sample:
  - If !valid, or valid && ready in that cycle: load data_rx, parity_err and frame_err; valid = 1; no overrun.
  - Else: keep the old word, assert overrun for 1 cycle, drop the new word.
  - A frame with frame_err is still delivered with frame_err = 1; the consumer decides what to do with it.
- valid && ready with no completing frame: valid -> 0 next cycle. data_rx and the error flags hold their last values.
- Latency: valid rises 1 cycle after the mid-stop-bit sample.
  - From the line's falling edge: 3 sync cycles + CLKS_PER_BIT/2 + (BITS_N + P + 1) * CLKS_PER_BIT + 1, where P = 1 with parity, else 0.
- Cycle counter: wide enough for CLKS_PER_BIT - 1. bit_n: $clog2(BITS_N) + 1 bits; no wrap beyond BITS_N - 1.
- A line stuck low after a stop bit that sampled 0 does not retrigger. A new falling edge is required.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START_BIT, DATA_BITS, PARITY_BIT, STOP_BIT);
  - PARITY_NONE/ODD/EVEN = 0/1/2;
  - a parity function parity_calc(data, type).
- uart_tx should adopt uart_pkg as well.
- One sub-module: sync_2ff, a generic single-bit synchroniser with a reset value parameter (1 here). It is reusable for other async inputs.

Test Plan:
(All scenarios use CLKS_PER_BIT = 16 and BITS_N = 8.)
- PARITY_TYPE = 0, ready held 1, send 0xA5 with a good stop bit -> valid high exactly 1 cycle, data_rx = 0xA5, parity_err = 0, frame_err = 0, overrun = 0; latency matches the formula.
- Line low for 5 cycles then high (glitch shorter than half a bit) -> no valid, FSM back in IDLE; a following 0x3C is received correctly.
- Send 0x3C with the stop bit driven 0 -> valid, data_rx = 0x3C, frame_err = 1. The line then returns high and 0x81 arrives with frame_err = 0.
- PARITY_TYPE = 2, send 0x07 with parity bit 0 -> parity_err = 1; the same word with parity bit 1 -> parity_err = 0. Repeat with PARITY_TYPE = 1: parity bit 0 -> parity_err = 0.
- ready = 0, send 0x11 then 0x22 back-to-back -> data_rx stays 0x11, overrun pulses 1 cycle after 0x22's stop sample. Then ready = 1 for 1 cycle -> valid = 0; a third byte 0x33 is received normally.
- Assert rst during data bit 3 of 0x5A -> all outputs reset immediately (async), no valid. After release and line idle, send 0x5A -> data_rx = 0x5A, no errors.
